vga_frame_capture: RTL and testbench

- Receive-side counterpart to the VGA sync/readout path: consumes a VGA-timed pixel stream (HS, VS, blank_n, 24-bit RGB) and writes one captured frame into the 8-bit colour-index frame RAM.
- Recovers pixel/line position from blank_n and VS.
- Quantises RGB to a 3-3-2 index and drives a RAM write port (address, data, write enable).
- Used for loopback self-test of the display path and for loading frames from an external VGA source.

---
 rtl/vga_frame_capture.sv | 224 ++++++++++++++++++++++
 tb/tb_vga_frame_capture.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_capture.sv
// Purpose : captures one VGA-timed RGB frame into the 8-bit 3-3-2 colour-index frame RAM.
// Latency : pixel at the input pins on cycle N -> we/wr_addr/wr_data on cycle N+2.
// Backpres: none; the video stream cannot be stalled, so the RAM must accept one write per cycle.
//
// Ports:
//   vga_clk, reset (sync, active-low)
//   capture_req    level request, sampled only in IDLE
//   HS, VS, blank_n, red/green/blue   incoming VGA stream (vga_clk domain)
//   wr_addr, wr_data, we              frame RAM write port
//   busy, frame_done, geom_err        status

module vga_frame_capture #(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 600,
  parameter int ADDR_W      = 19,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              capture_req,
  input  logic              HS,
  input  logic              VS,
  input  logic              blank_n,
  input  logic [7:0]        red,
  input  logic [7:0]        green,
  input  logic [7:0]        blue,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              we,
  output logic              busy,
  output logic              frame_done,
  output logic              geom_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [31:0] H_A32 = 32'(H_ACTIVE);
  localparam logic [31:0] V_A32 = 32'(V_ACTIVE);

  state_t r_state;
  state_t w_state_next;

  // Stage 1: registered copies of the stream, plus one-cycle history
  // of VS and blank_n for edge detection.
  logic        r_hs;
  logic        r_vs;
  logic        r_blank;
  logic [23:0] r_rgb;
  logic        r_vs_d;
  logic        r_blank_d;

  logic [10:0] r_x;
  logic [9:0]  r_y;

  logic        w_vs_start;
  logic        w_vs_end;
  logic        w_blank_fall;
  logic        w_in_cap;
  logic        w_pix;
  logic        w_x_ok;
  logic        w_y_ok;
  logic        w_wr;
  logic [31:0] w_x32;
  logic [31:0] w_y32;
  logic [31:0] w_addr_full;
  logic [9:0]  w_y_inc;
  logic [9:0]  w_y_end;
  logic [7:0]  w_index;
  logic        w_geom_hit;
  logic        w_unused_bits;

  // ---------------------------------------------------------------
  // Stage 1 input registers
  // ---------------------------------------------------------------
  always_ff @(posedge vga_clk) begin
    if (!reset) begin
      r_hs      <= 1'b0;
      r_vs      <= 1'b0;
      r_blank   <= 1'b0;
      r_rgb     <= 24'd0;
      r_vs_d    <= 1'b0;
      r_blank_d <= 1'b0;
    end else begin
      r_hs      <= HS;
      r_vs      <= VS;
      r_blank   <= blank_n;
      r_rgb     <= {red, green, blue};
      r_vs_d    <= r_vs;
      r_blank_d <= r_blank;
    end
  end

  assign w_vs_start   = (r_vs == SYNC_ACTIVE) && (r_vs_d != SYNC_ACTIVE);
  assign w_vs_end     = (r_vs_d == SYNC_ACTIVE) && (r_vs != SYNC_ACTIVE);
  assign w_blank_fall = r_blank_d && !r_blank;

  // ---------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------
  always_ff @(posedge vga_clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    frame_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (capture_req) begin
          w_state_next = S_ARM;
        end
      end
      S_ARM: begin
        busy = 1'b1;
        // Only the end of vertical sync starts a capture, so a frame that
        // is already being scanned out is skipped as a whole.
        if (w_vs_end) begin
          w_state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        busy = 1'b1;
        if (w_vs_start) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        frame_done   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Position counters
  // ---------------------------------------------------------------
  assign w_in_cap = (r_state == S_CAPTURE);
  assign w_pix    = w_in_cap && r_blank;
  assign w_x32    = {21'd0, r_x};
  assign w_y32    = {22'd0, r_y};
  assign w_x_ok   = (w_x32 < H_A32);
  assign w_y_ok   = (w_y32 < V_A32);
  assign w_wr     = w_pix && w_x_ok && w_y_ok;

  // Counters saturate so a runaway line or frame can never wrap back
  // into a valid address.
  assign w_y_inc  = (r_y != '1) ? (r_y + 10'd1) : r_y;
  // Line count as it will be after this cycle; used for the DONE-entry
  // check in case the last blank edge and VS coincide.
  assign w_y_end  = w_blank_fall ? w_y_inc : r_y;

  always_ff @(posedge vga_clk) begin
    if (!reset) begin
      r_x <= 11'd0;
      r_y <= 10'd0;
    end else if (!w_in_cap) begin
      r_x <= 11'd0;
      r_y <= 10'd0;
    end else if (w_blank_fall) begin
      r_x <= 11'd0;
      r_y <= w_y_inc;
    end else if (r_blank && (r_x != '1)) begin
      r_x <= r_x + 11'd1;
    end
  end

  // ---------------------------------------------------------------
  // Geometry error (sticky until the next capture start)
  // ---------------------------------------------------------------
  assign w_geom_hit = w_in_cap &&
                      ((w_pix && !w_x_ok) ||
                       (w_pix && !w_y_ok) ||
                       (w_blank_fall && (w_x32 != H_A32)) ||
                       (w_vs_start && ({22'd0, w_y_end} != V_A32)));

  always_ff @(posedge vga_clk) begin
    if (!reset) begin
      geom_err <= 1'b0;
    end else if ((r_state == S_IDLE) && capture_req) begin
      geom_err <= 1'b0;
    end else if (w_geom_hit) begin
      geom_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Stage 2: RAM write port
  // ---------------------------------------------------------------
  assign w_addr_full = (w_y32 * H_A32) + w_x32;
  assign w_index     = {r_rgb[23:21], r_rgb[15:13], r_rgb[7:6]};

  always_ff @(posedge vga_clk) begin
    if (!reset) begin
      we      <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'd0;
    end else begin
      we <= w_wr;
      if (w_wr) begin
        wr_addr <= w_addr_full[ADDR_W-1:0];
        wr_data <= w_index;
      end
    end
  end

  // HS carries no information once blank_n is present; the low colour
  // bits are dropped by the 3-3-2 quantiser.
  assign w_unused_bits = ^{r_hs, r_rgb[20:16], r_rgb[12:8], r_rgb[5:0],
                           w_addr_full[31:ADDR_W]};

endmodule

// File: tb/tb_vga_frame_capture.sv
module tb_vga_frame_capture;

  localparam int   H    = 16;
  localparam int   V    = 8;
  localparam int   AW   = 7;
  localparam int   NPIX = H * V;
  localparam int   LINE = H + 4;
  localparam logic ACT  = 1'b0;

  logic          vga_clk = 1'b0;
  logic          reset;
  logic          capture_req;
  logic          HS;
  logic          VS;
  logic          blank_n;
  logic [7:0]    red;
  logic [7:0]    green;
  logic [7:0]    blue;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          we;
  logic          busy;
  logic          frame_done;
  logic          geom_err;

  always #5 vga_clk = ~vga_clk;

  vga_frame_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .SYNC_ACTIVE(1'b0)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .capture_req(capture_req),
    .HS(HS), .VS(VS), .blank_n(blank_n),
    .red(red), .green(green), .blue(blue),
    .wr_addr(wr_addr), .wr_data(wr_data), .we(we),
    .busy(busy), .frame_done(frame_done), .geom_err(geom_err)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge vga_clk) cyc <= cyc + 1;

  // Reference picture: one 24-bit pixel per position, with a spare
  // column for the over-long line.
  logic [23:0] px [0:V-1][0:H];
  int          drv_cyc [0:NPIX-1];
  int          vs_pin_cyc = -1;

  // Snapshot around the mid-capture reset
  logic rst_we;
  logic rst_busy;
  int   rst_wcnt;

  // Write monitor, observing on the falling edge
  logic       mon_clr = 1'b1;
  logic [7:0] mem [0:NPIX-1];
  int         wr_cyc [0:NPIX-1];
  int         wr_cnt, done_cnt, done_cyc, first_addr, last_addr;

  always @(negedge vga_clk) begin
    if (mon_clr) begin
      wr_cnt     = 0;
      done_cnt   = 0;
      done_cyc   = -1;
      first_addr = -1;
      last_addr  = -1;
      for (int i = 0; i < NPIX; i++) begin
        mem[i]    = 8'h00;
        wr_cyc[i] = -1;
      end
    end else begin
      if (we === 1'b1) begin
        if (wr_cnt == 0) first_addr = int'(wr_addr);
        last_addr = int'(wr_addr);
        if (int'(wr_addr) < NPIX) begin
          mem[wr_addr]    = wr_data;
          wr_cyc[wr_addr] = cyc;
        end
        wr_cnt++;
      end
      if (frame_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic logic [7:0] quant(input logic [23:0] p);
    return {p[23:21], p[15:13], p[7:6]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic pulse_req();
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
  endtask

  task automatic fill_px();
    for (int y = 0; y < V; y++)
      for (int x = 0; x <= H; x++)
        px[y][x] = 24'($urandom());
  endtask

  task automatic send_blank_line(input bit vs);
    if (vs && (VS != ACT)) vs_pin_cyc = cyc;
    for (int c = 0; c < LINE; c++) begin
      VS      = vs ? ACT : ~ACT;
      HS      = (c >= 1 && c < 3) ? ACT : ~ACT;
      blank_n = 1'b0;
      {red, green, blue} = 24'd0;
      tick();
    end
  endtask

  task automatic send_active_line(input int y, input int npx, input int rst_at, input bit req);
    if (req) capture_req = 1'b1;
    VS = ~ACT;
    for (int x = 0; x < npx; x++) begin
      reset   = (x == rst_at) ? 1'b0 : 1'b1;
      HS      = ~ACT;
      blank_n = 1'b1;
      {red, green, blue} = px[y][x];
      if (x < H) drv_cyc[y*H + x] = cyc;
      tick();
      if (x == rst_at) begin
        rst_we   = we;
        rst_busy = busy;
        rst_wcnt = wr_cnt;
      end
    end
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      HS      = (c >= 1 && c < 3) ? ACT : ~ACT;
      blank_n = 1'b0;
      {red, green, blue} = 24'd0;
      tick();
    end
    if (req) capture_req = 1'b0;
  endtask

  task automatic send_frame(input int long_line, input int req_line, input int rst_line);
    send_blank_line(1'b1);
    send_blank_line(1'b0);
    for (int y = 0; y < V; y++)
      send_active_line(y, (y == long_line) ? H + 1 : H,
                       (y == rst_line) ? H / 2 : -1, y == req_line);
    send_blank_line(1'b0);
  endtask

  task automatic check_frame(input string tag);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        check($sformatf("%s_pix_%0d_%0d", tag, y, x),
              32'(mem[y*H + x]), 32'(quant(px[y][x])));
  endtask

  initial begin
    reset       = 1'b0;
    capture_req = 1'b0;
    HS          = ~ACT;
    VS          = ~ACT;
    blank_n     = 1'b0;
    {red, green, blue} = 24'd0;

    // Reset held for 3 cycles over live active video
    for (int i = 0; i < 3; i++) begin
      blank_n = 1'b1;
      {red, green, blue} = 24'($urandom());
      tick();
      check($sformatf("rst_we_%0d", i),   32'(we),       32'd0);
      check($sformatf("rst_busy_%0d", i), 32'(busy),     32'd0);
      check($sformatf("rst_geom_%0d", i), 32'(geom_err), 32'd0);
      check($sformatf("rst_addr_%0d", i), 32'(wr_addr),  32'd0);
    end
    reset   = 1'b1;
    blank_n = 1'b0;
    mon_clr = 1'b0;

    // No capture without a request
    fill_px();
    send_frame(-1, -1, -1);
    send_blank_line(1'b1);
    check("idle_no_writes", 32'(wr_cnt), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_no_done", 32'(done_cnt), 32'd0);

    // Full frame with random pixels and two fixed quantiser vectors
    fill_px();
    px[0][0] = 24'hFF8040;
    px[0][1] = 24'h1FE0C0;
    clr_mon();
    pulse_req();
    check("arm_busy", 32'(busy), 32'd1);
    send_frame(-1, -1, -1);
    send_blank_line(1'b1);
    check("full_count", 32'(wr_cnt), 32'(NPIX));
    check("full_first", 32'(first_addr), 32'd0);
    check("full_last", 32'(last_addr), 32'(NPIX - 1));
    check("quant_ff8040", 32'(mem[0]), 32'h0000_00F1);
    check("quant_1fe0c0", 32'(mem[1]), 32'h0000_001F);
    check("lat_first", 32'(wr_cyc[0] - drv_cyc[0]), 32'd2);
    check("lat_second", 32'(wr_cyc[1] - drv_cyc[1]), 32'd2);
    check("lat_last", 32'(wr_cyc[NPIX-1] - drv_cyc[NPIX-1]), 32'd2);
    check("full_done_cnt", 32'(done_cnt), 32'd1);
    check("full_done_time", 32'(done_cyc), 32'(vs_pin_cyc + 2));
    check("full_geom", 32'(geom_err), 32'd0);
    check("full_idle", 32'(busy), 32'd0);
    check_frame("full");

    // Arm in the middle of a frame: that frame must be skipped entirely
    fill_px();
    clr_mon();
    send_frame(-1, V / 2, -1);
    check("midarm_no_writes", 32'(wr_cnt), 32'd0);
    check("midarm_busy", 32'(busy), 32'd1);
    fill_px();
    send_frame(-1, -1, -1);
    send_blank_line(1'b1);
    check("midarm_count", 32'(wr_cnt), 32'(NPIX));
    check("midarm_first", 32'(first_addr), 32'd0);
    check("midarm_done", 32'(done_cnt), 32'd1);
    check("midarm_geom", 32'(geom_err), 32'd0);
    check_frame("midarm");

    // One over-long line: extra pixel dropped, sticky geometry error
    fill_px();
    clr_mon();
    pulse_req();
    send_frame(2, -1, -1);
    check("geom_set", 32'(geom_err), 32'd1);
    check("geom_count", 32'(wr_cnt), 32'(NPIX));
    send_blank_line(1'b1);
    check("geom_sticky_done", 32'(geom_err), 32'd1);
    check("geom_done", 32'(done_cnt), 32'd1);
    check_frame("geom");
    pulse_req();
    check("geom_cleared", 32'(geom_err), 32'd0);

    // Reset in the middle of the capture started above
    fill_px();
    clr_mon();
    send_frame(-1, -1, V / 2);
    check("midrst_we", 32'(rst_we), 32'd0);
    check("midrst_busy", 32'(rst_busy), 32'd0);
    check("midrst_wcnt", 32'(rst_wcnt), 32'((V / 2) * H + H / 2 - 1));
    check("midrst_no_more", 32'(wr_cnt), 32'(rst_wcnt));
    check("midrst_idle", 32'(busy), 32'd0);
    send_blank_line(1'b1);
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    fill_px();
    clr_mon();
    pulse_req();
    send_frame(-1, -1, -1);
    send_blank_line(1'b1);
    check("clean_count", 32'(wr_cnt), 32'(NPIX));
    check("clean_geom", 32'(geom_err), 32'd0);
    check("clean_done", 32'(done_cnt), 32'd1);
    check_frame("clean");

    // capture_req held high: two consecutive frames
    fill_px();
    clr_mon();
    capture_req = 1'b1;
    send_frame(-1, -1, -1);
    send_frame(-1, 0, -1);
    send_blank_line(1'b1);
    check("b2b_count", 32'(wr_cnt), 32'(2 * NPIX));
    check("b2b_done", 32'(done_cnt), 32'd2);
    check("b2b_geom", 32'(geom_err), 32'd0);
    check("b2b_idle", 32'(busy), 32'd0);
    check_frame("b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
